ssk_cmd_parser: RTL and testbench
=================================

# ssk_cmd_parser

Upstream front end of the secure-session-key control unit. Collects bytes from the SPI slave receiver into a 5-byte command header and presents it as `cmd_op`, `cmd_extend` and `wr_size` with a `cmd_en`/`cmd_rdy` handshake. For write commands it packs the payload big-endian into 32-bit words and issues one `wr_en` per word after the core grants the write. Truncated frames abort the core through `clr_ssk`.

## Interface
- `FIFO_AW`, default 1: word FIFO address width; depth is 2^FIFO_AW words.
- `clk  in  1`: single clock.
- `rst  in  1`: synchronous, active-high reset.
- `frame_act  in  1`: chip-select active; high for the whole frame.
- `rx_valid  in  1`: one-cycle strobe, `rx_data` holds a received byte.
- `rx_data  in  8`: received byte.
- `cmd_rdy  in  1`: core accepts a command.
- `cmd_en  out  1`: command valid.
- `cmd_op  out  8`: opcode (header byte 0).
- `cmd_extend  out  16`: header bytes 1–2, MSB first.
- `wr_size  out  16`: header bytes 3–4, MSB first; payload length in bytes.
- `wr_en  out  1`: payload word strobe.
- `wr_data  out  32`: payload word, first byte in [31:24].
- `wr_open  in  1`: core write-grant pulse.
- `rd_open  in  1`: core read-grant pulse.
- `resp_done  in  1`: core response pulse.
- `resp_err  in  2`: core error code, valid with `resp_done`.
- `clr_ssk  out  1`: one-cycle core abort.
- `hdr_err  out  1`: one-cycle pulse, header incomplete at frame end.
- `ovf_err  out  1`: one-cycle pulse, word FIFO overflow.
- `busy  out  1`: state is not IDLE.

## Operation
- Reset values: all outputs 0, header registers 0, FIFO empty, state IDLE.
- IDLE: enter HDR on `frame_act`. A byte arriving in the same cycle is accepted as header byte 0.
- HDR: byte counter 0..4 latches the fields.
  - 5th byte received: go to ISSUE; load `remaining` ← `wr_size` bytes.
  - `frame_act` low before the 5th byte: `hdr_err` pulse, go to IDLE.
- ISSUE: `cmd_en`=1 until a cycle with `cmd_rdy`=1, which is the transfer, then go to GRANT. Header outputs stay stable from ISSUE until state returns to IDLE.
- Payload packing runs in ISSUE, GRANT and PAYLOAD when `cmd_op[7:4]`=1:
  - Each byte decrements `remaining` and is shifted into the pack register.
  - A word is pushed when 4 bytes are collected, or when `remaining` reaches 0; unfilled low bytes are 0.
  - Bytes arriving with `remaining`=0 are ignored.
- GRANT:
  - `wr_open` → PAYLOAD.
  - `rd_open` → FLUSH.
  - `resp_done` → FIFO cleared, FLUSH.
- PAYLOAD: `wr_en`=1 with `wr_data`=FIFO head whenever the FIFO is non-empty, at most one pop per cycle. When all ceil(`wr_size`/4) words are popped, go to DONE_WAIT.
- DONE_WAIT: `resp_done` → FLUSH.
- FLUSH: ignore bytes; return to IDLE when `frame_act` is low.
- Truncation: in GRANT or PAYLOAD, write op, `frame_act` low and `remaining`≠0 → `clr_ssk` pulse, FIFO cleared, pack register cleared, go to IDLE.
- Overflow: push with FIFO full → `ovf_err` and `clr_ssk` pulses, FIFO cleared, go to FLUSH.
- `wr_size`=0 write: no words; after `wr_open` go directly to DONE_WAIT.

## Timing
- `cmd_en` rises the cycle after the 5th header byte and drops the cycle after the `cmd_en`&`cmd_rdy` transfer.
- No `wr_en` in the `wr_open` cycle, because the core loads its size counter then. The first `wr_en` is at the earliest cycle after `wr_open`.
- Word push is registered: it happens the cycle after the completing byte. A pop is possible in the following cycle.
- Simultaneous push and pop on a full FIFO is not an overflow.
- Truncation check has priority over a pop in the same cycle.
- `rst` mid-frame returns to IDLE next cycle with no `clr_ssk` pulse. The core is reset separately.
- Frame spans bytes only. A new frame is recognised only from IDLE.

## Structure
- `ssk_pkg`: state encodings (IDLE, HDR, ISSUE, GRANT, PAYLOAD, DONE_WAIT, FLUSH), `HDR_LEN`=5, `WORD_BYTES`=4, and `ERR_CMD`/`ERR_SIZE`/`ERR_PRM` shared with the core.
- Sub-module `ssk_word_fifo`: synchronous 32-bit FIFO with full, empty and clear. Depth is 2^`FIFO_AW`.
- The parser FSM, header registers, pack register and counters stay in `ssk_cmd_parser`.

## Test plan
- Write: bytes 13 00 00 00 08 01..08; core model grants. Required:
  - `cmd_op`=0x13, `cmd_extend`=0, `wr_size`=8.
  - `wr_en` carries 0x01020304, then 0x05060708.
  - After `resp_done`/0 and `frame_act` low, `busy`=0.
- Partial word: 13 00 00 00 06 AA BB CC DD EE FF → words 0xAABBCCDD, 0xEEFF0000; no third `wr_en`.
- Read: 02 00 20 00 00 plus 3 trailing bytes, core returns `rd_open`. Required: one `cmd_en` transfer, no `wr_en`, trailing bytes ignored.
- Size error: 13 00 00 00 40 plus payload, core returns `resp_done` with `resp_err`=2'b10. Required: FIFO flushed, zero `wr_en`, IDLE after frame end.
- Truncation: 13 00 00 00 08 01..05, then `frame_act` low. Required: one `wr_en` of 0x01020304, then one `clr_ssk` pulse, no second word.
- Short header and reset:
  - 3 header bytes, then frame end → one `hdr_err` pulse, no `cmd_en`.
  - `rst` asserted mid-payload → all outputs 0 the next cycle.

Source files
------------

// File: rtl/ssk_pkg.sv
// Shared encodings for the secure-session-key front end: parser states,
// header geometry and the error codes the core reports with resp_done.
package ssk_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_HDR       = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_GRANT     = 3'd3;
   localparam logic [2:0] ST_PAYLOAD   = 3'd4;
   localparam logic [2:0] ST_DONE_WAIT = 3'd5;
   localparam logic [2:0] ST_FLUSH     = 3'd6;

   localparam int HDR_LEN    = 5;
   localparam int WORD_BYTES = 4;

   localparam logic [1:0] ERR_CMD  = 2'b01;
   localparam logic [1:0] ERR_SIZE = 2'b10;
   localparam logic [1:0] ERR_PRM  = 2'b11;

   // Opcodes whose upper nibble is 1 carry a write payload.
   localparam logic [3:0] OP_WR_CLASS = 4'h1;

   function automatic logic [14:0] size_to_words(input logic [15:0] size);
      logic [16:0] padded;
      padded = {1'b0, size} + 17'd3;
      return padded[16:2];
   endfunction

endpackage

// File: rtl/ssk_word_fifo.sv
// Synchronous 32-bit word FIFO, depth 2^AW, with clear. A push while full is
// accepted only when a pop frees the head slot in the same cycle.
module ssk_word_fifo #(
   parameter int AW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        full,
   output logic        empty
);

   logic [31:0] mem [2**AW];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ssk_cmd_parser.sv
// SPI byte stream to command header plus big-endian payload words for the
// secure-session-key core; aborts the core on truncated frames.
//
// state     | meaning
// IDLE      | no frame; waiting for frame_act
// HDR       | collecting the 5 header bytes
// ISSUE     | cmd_en high until the core takes the command
// GRANT     | waiting for wr_open / rd_open / resp_done
// PAYLOAD   | streaming packed words to the core
// DONE_WAIT | all words delivered, waiting for resp_done
// FLUSH     | discarding bytes until the frame ends
module ssk_cmd_parser
   import ssk_pkg::*;
#(
   parameter int FIFO_AW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_act,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        cmd_rdy,
   output logic        cmd_en,
   output logic [7:0]  cmd_op,
   output logic [15:0] cmd_extend,
   output logic [15:0] wr_size,
   output logic        wr_en,
   output logic [31:0] wr_data,
   input  logic        wr_open,
   input  logic        rd_open,
   input  logic        resp_done,
   input  logic [1:0]  resp_err,
   output logic        clr_ssk,
   output logic        hdr_err,
   output logic        ovf_err,
   output logic        busy
);

   logic [2:0]  state;
   logic [2:0]  hdr_cnt;
   logic [15:0] remaining;
   logic [14:0] words_left;
   logic [31:0] pack_reg;
   logic [31:0] pack_next;
   logic [1:0]  pack_cnt;
   logic        push_pend;
   logic [31:0] push_data;

   logic        is_wr;
   logic        in_pack;
   logic        byte_in;
   logic        trunc;
   logic        ovf;
   logic        grant_abort;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_clr;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_dout;
   logic        unused_ok;

   // Error code is consumed by the core's own status path, not here.
   assign unused_ok = ^resp_err;

   assign is_wr       = (cmd_op[7:4] == OP_WR_CLASS);
   assign in_pack     = (state == ST_ISSUE) || (state == ST_GRANT) || (state == ST_PAYLOAD);
   assign byte_in     = in_pack && rx_valid && is_wr && (remaining != 16'd0);
   assign trunc       = ((state == ST_GRANT) || (state == ST_PAYLOAD)) && is_wr
                        && !frame_act && (remaining != 16'd0);
   assign fifo_pop    = (state == ST_PAYLOAD) && !fifo_empty && !trunc;
   assign fifo_push   = push_pend && in_pack;
   assign ovf         = fifo_push && fifo_full && !fifo_pop && !trunc;
   assign grant_abort = (state == ST_GRANT) && !trunc && !wr_open && !rd_open && resp_done;
   assign fifo_clr    = trunc || ovf || grant_abort || (state == ST_IDLE) || (state == ST_FLUSH);

   assign cmd_en  = (state == ST_ISSUE);
   assign wr_en   = fifo_pop;
   assign wr_data = fifo_pop ? fifo_dout : 32'd0;
   assign busy    = (state != ST_IDLE);

   always_comb begin
      pack_next = pack_reg;
      case (pack_cnt)
         2'd0:    pack_next[31:24] = rx_data;
         2'd1:    pack_next[23:16] = rx_data;
         2'd2:    pack_next[15:8]  = rx_data;
         default: pack_next[7:0]   = rx_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         hdr_cnt    <= 3'd0;
         cmd_op     <= 8'd0;
         cmd_extend <= 16'd0;
         wr_size    <= 16'd0;
         remaining  <= 16'd0;
         words_left <= 15'd0;
         pack_reg   <= 32'd0;
         pack_cnt   <= 2'd0;
         push_pend  <= 1'b0;
         push_data  <= 32'd0;
         clr_ssk    <= 1'b0;
         hdr_err    <= 1'b0;
         ovf_err    <= 1'b0;
      end else begin
         clr_ssk   <= 1'b0;
         hdr_err   <= 1'b0;
         ovf_err   <= 1'b0;
         push_pend <= 1'b0;

         if (byte_in) begin
            remaining <= remaining - 16'd1;
            if ((pack_cnt == 2'(WORD_BYTES - 1)) || (remaining == 16'd1)) begin
               push_pend <= 1'b1;
               push_data <= pack_next;
               pack_reg  <= 32'd0;
               pack_cnt  <= 2'd0;
            end else begin
               pack_reg <= pack_next;
               pack_cnt <= pack_cnt + 2'd1;
            end
         end

         case (state)
            ST_IDLE: begin
               pack_reg <= 32'd0;
               pack_cnt <= 2'd0;
               hdr_cnt  <= 3'd0;
               if (frame_act) begin
                  state      <= ST_HDR;
                  cmd_op     <= rx_valid ? rx_data : 8'd0;
                  cmd_extend <= 16'd0;
                  wr_size    <= 16'd0;
                  hdr_cnt    <= rx_valid ? 3'd1 : 3'd0;
               end
            end
            ST_HDR: begin
               if (!frame_act) begin
                  hdr_err <= 1'b1;
                  state   <= ST_IDLE;
               end else if (rx_valid) begin
                  hdr_cnt <= hdr_cnt + 3'd1;
                  case (hdr_cnt)
                     3'd0: cmd_op           <= rx_data;
                     3'd1: cmd_extend[15:8] <= rx_data;
                     3'd2: cmd_extend[7:0]  <= rx_data;
                     3'd3: wr_size[15:8]    <= rx_data;
                     default: begin
                        wr_size[7:0] <= rx_data;
                        state        <= ST_ISSUE;
                        remaining    <= is_wr ? {wr_size[15:8], rx_data} : 16'd0;
                        words_left   <= is_wr ? size_to_words({wr_size[15:8], rx_data}) : 15'd0;
                     end
                  endcase
               end
            end
            ST_ISSUE: begin
               if (cmd_rdy) state <= ST_GRANT;
            end
            ST_GRANT: begin
               if (wr_open)        state <= (words_left == 15'd0) ? ST_DONE_WAIT : ST_PAYLOAD;
               else if (rd_open)   state <= ST_FLUSH;
               else if (resp_done) state <= ST_FLUSH;
            end
            ST_PAYLOAD: begin
               if (fifo_pop) begin
                  words_left <= words_left - 15'd1;
                  if (words_left == 15'd1) state <= ST_DONE_WAIT;
               end
            end
            ST_DONE_WAIT: begin
               if (resp_done) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (!frame_act) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // Truncation outranks overflow and any normal transition.
         if (trunc) begin
            clr_ssk   <= 1'b1;
            state     <= ST_IDLE;
            pack_reg  <= 32'd0;
            pack_cnt  <= 2'd0;
            push_pend <= 1'b0;
         end else if (ovf) begin
            ovf_err <= 1'b1;
            clr_ssk <= 1'b1;
            state   <= ST_FLUSH;
         end
      end
   end

   ssk_word_fifo #(
      .AW(FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (fifo_clr),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (push_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_ssk_cmd_parser.sv
// Scoreboard bench for ssk_cmd_parser: frames are driven byte by byte while a
// small core model answers the handshake; expected words are queued up front.
module tb_ssk_cmd_parser;

   localparam int M_WR    = 0;
   localparam int M_TRUNC = 1;
   localparam int M_RD    = 2;
   localparam int M_ERR   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_act = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        cmd_rdy = 1'b0;
   logic        cmd_en;
   logic [7:0]  cmd_op;
   logic [15:0] cmd_extend;
   logic [15:0] wr_size;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        wr_open = 1'b0;
   logic        rd_open = 1'b0;
   logic        resp_done = 1'b0;
   logic [1:0]  resp_err = 2'b00;
   logic        clr_ssk;
   logic        hdr_err;
   logic        ovf_err;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int xfer_cnt = 0;
   int clr_cnt = 0;
   int hdr_cnt = 0;
   int ovf_cnt = 0;
   logic [7:0]  x_op;
   logic [15:0] x_ext;
   logic [15:0] x_size;

   logic [31:0] sb_q[$];
   logic [7:0]  frame_q[$];

   always #5 clk = ~clk;

   ssk_cmd_parser #(.FIFO_AW(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_act  (frame_act),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .cmd_rdy    (cmd_rdy),
      .cmd_en     (cmd_en),
      .cmd_op     (cmd_op),
      .cmd_extend (cmd_extend),
      .wr_size    (wr_size),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_open    (wr_open),
      .rd_open    (rd_open),
      .resp_done  (resp_done),
      .resp_err   (resp_err),
      .clr_ssk    (clr_ssk),
      .hdr_err    (hdr_err),
      .ovf_err    (ovf_err),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            wr_cnt++;
            if (sb_q.size() == 0) chk("wr_unexpected", 32'(sb_q.size()), 32'd1);
            else                  chk("wr_data", wr_data, sb_q.pop_front());
         end
         if (wr_open) chk("wr_en_in_open", 32'(wr_en), 32'd0);
         if (cmd_en && cmd_rdy) begin
            xfer_cnt++;
            x_op   = cmd_op;
            x_ext  = cmd_extend;
            x_size = wr_size;
         end
         if (clr_ssk) clr_cnt++;
         if (hdr_err) hdr_cnt++;
         if (ovf_err) ovf_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic send_frame();
      frame_act = 1'b1;
      tick();
      foreach (frame_q[i]) send_byte(frame_q[i]);
      tick();
      frame_act = 1'b0;
      tick();
   endtask

   // Reference packer: big-endian words, partial tail zero-filled, bytes past
   // the declared size dropped, incomplete word lost if the frame is short.
   task automatic model_push();
      int          size;
      int          rem;
      int          cnt;
      logic [31:0] acc;
      size = int'({frame_q[3], frame_q[4]});
      rem  = size;
      cnt  = 0;
      acc  = 32'd0;
      for (int i = 5; i < frame_q.size(); i++) begin
         if (rem == 0) break;
         acc = acc | (32'(frame_q[i]) << (8 * (3 - cnt)));
         cnt++;
         rem--;
         if (cnt == 4 || rem == 0) begin
            sb_q.push_back(acc);
            acc = 32'd0;
            cnt = 0;
         end
      end
   endtask

   task automatic core_run(input int mode, input int nwords);
      int t;
      int base;
      base = wr_cnt;
      t = 0;
      while (!cmd_en && t < 100) begin
         tick();
         t++;
      end
      chk("cmd_en_seen", 32'(cmd_en), 32'd1);
      tick();
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      tick();
      case (mode)
         M_WR: begin
            wr_open = 1'b1;
            tick();
            wr_open = 1'b0;
            t = 0;
            while (wr_cnt < base + nwords && t < 300) begin
               tick();
               t++;
            end
            chk("wr_wait", 32'(wr_cnt - base), 32'(nwords));
            tick();
            resp_done = 1'b1;
            resp_err  = 2'b00;
            tick();
            resp_done = 1'b0;
         end
         M_TRUNC: begin
            wr_open = 1'b1;
            tick();
            wr_open = 1'b0;
         end
         M_RD: begin
            rd_open = 1'b1;
            tick();
            rd_open = 1'b0;
         end
         default: begin
            resp_done = 1'b1;
            resp_err  = 2'b10;
            tick();
            resp_done = 1'b0;
            resp_err  = 2'b00;
         end
      endcase
   endtask

   task automatic run_cmd(input string name, input int mode, input logic [7:0] e_op,
                          input logic [15:0] e_ext, input logic [15:0] e_size,
                          input int e_wr, input int e_clr);
      int b_wr, b_xfer, b_clr, b_hdr, b_ovf;
      b_wr = wr_cnt; b_xfer = xfer_cnt; b_clr = clr_cnt; b_hdr = hdr_cnt; b_ovf = ovf_cnt;
      if (mode == M_WR || mode == M_TRUNC) model_push();
      fork
         send_frame();
         core_run(mode, e_wr);
      join
      repeat (5) tick();
      chk({name, "_xfers"}, 32'(xfer_cnt - b_xfer), 32'd1);
      chk({name, "_op"}, 32'(x_op), 32'(e_op));
      chk({name, "_ext"}, 32'(x_ext), 32'(e_ext));
      chk({name, "_size"}, 32'(x_size), 32'(e_size));
      chk({name, "_wr_cnt"}, 32'(wr_cnt - b_wr), 32'(e_wr));
      chk({name, "_clr"}, 32'(clr_cnt - b_clr), 32'(e_clr));
      chk({name, "_hdr_err"}, 32'(hdr_cnt - b_hdr), 32'd0);
      chk({name, "_ovf"}, 32'(ovf_cnt - b_ovf), 32'd0);
      chk({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_zero(input string name);
      chk({name, "_ctl"}, 32'({cmd_en, cmd_op, cmd_extend, wr_en, clr_ssk, hdr_err, ovf_err, busy}), 32'd0);
      chk({name, "_size"}, 32'(wr_size), 32'd0);
      chk({name, "_wdata"}, wr_data, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int b_wr, b_xfer, b_clr, b_hdr, t;

      repeat (3) tick();
      @(negedge clk);
      check_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      frame_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h08,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_cmd("write", M_WR, 8'h13, 16'h0000, 16'd8, 2, 0);

      frame_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h06,
                  8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      run_cmd("partial", M_WR, 8'h13, 16'h0000, 16'd6, 2, 0);

      frame_q = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h77, 8'h88, 8'h99};
      run_cmd("read", M_RD, 8'h02, 16'h0020, 16'd0, 0, 0);

      frame_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h40,
                  8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
      run_cmd("size_err", M_ERR, 8'h13, 16'h0000, 16'h0040, 0, 0);

      frame_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h08,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run_cmd("trunc", M_TRUNC, 8'h13, 16'h0000, 16'd8, 1, 1);

      b_xfer = xfer_cnt; b_hdr = hdr_cnt;
      frame_q = '{8'h13, 8'h00, 8'h00};
      send_frame();
      repeat (3) tick();
      chk("short_hdr_err", 32'(hdr_cnt - b_hdr), 32'd1);
      chk("short_xfers", 32'(xfer_cnt - b_xfer), 32'd0);
      chk("short_busy", 32'(busy), 32'd0);

      // Reset in the middle of a payload, after one word has gone out.
      b_wr = wr_cnt; b_clr = clr_cnt;
      sb_q.push_back(32'h11223344);
      frame_act = 1'b1;
      tick();
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
      t = 0;
      while (!cmd_en && t < 50) begin tick(); t++; end
      chk("rstmid_cmd_en", 32'(cmd_en), 32'd1);
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      wr_open = 1'b1;
      tick();
      wr_open = 1'b0;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      t = 0;
      while (wr_cnt == b_wr && t < 50) begin tick(); t++; end
      chk("rstmid_wr_cnt", 32'(wr_cnt - b_wr), 32'd1);
      send_byte(8'h55);
      chk("rstmid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      frame_act = 1'b0;
      tick();
      @(negedge clk);
      check_zero("rstmid");
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("rstmid_clr", 32'(clr_cnt - b_clr), 32'd0);
      chk("rstmid_sb_left", 32'(sb_q.size()), 32'd0);
      chk("rstmid_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
